// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port 512x16 RAM between the CPU memory port
// and a secondary requester (program loader / debug / DMA). The CPU wins by
// default. A waiting loader is forced through after STARVE lost cycles. A
// locked loader keeps the RAM for back-to-back download while the CPU stalls.
// Read data from the synchronous RAM is steered back to whichever requester
// owned the RAM in the previous cycle.
module mem_arbiter #(
  parameter int AW     = 9,
  parameter int DW     = 16,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cpu_cmd,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic          ldr_lock,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_valid,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int              SW         = $clog2(STARVE + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE);

  // The state names the owner of the RAM in the cycle that just completed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    LDR  = 2'd2,
    LOCK = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [SW-1:0] r_starveCnt;
  logic [SW-1:0] w_nextStarve;
  logic [AW-1:0] r_lastAddr;
  logic          r_cpuRd;
  logic          r_ldrRd;
  logic [DW-1:0] r_cpuRdata;

  logic          w_cpuRead;
  logic          w_cpuWrite;
  logic          w_cpuReq;
  logic          w_ldrGnt;
  logic          w_cpuGnt;

  // Decode the CPU command and decide who owns the RAM this cycle.
  always_comb begin
    w_cpuRead  = (cpu_cmd == 2'b01);
    w_cpuWrite = (cpu_cmd == 2'b10);
    w_cpuReq   = w_cpuRead | w_cpuWrite;
    w_ldrGnt   = 1'b0;
    w_cpuGnt   = 1'b0;
    if (!reset) begin
      if (r_state == LOCK) begin
        w_ldrGnt = ldr_req;
      end else begin
        w_ldrGnt = ldr_req && (!w_cpuReq || (r_starveCnt == STARVE_MAX));
      end
      // A locked loader keeps the CPU out even in cycles it leaves unused.
      w_cpuGnt = w_cpuReq && !w_ldrGnt && (r_state != LOCK);
    end
  end

  // Steer the granted requester onto the RAM port; hold the address when idle.
  always_comb begin
    ram_addr = r_lastAddr;
    ram_we   = 1'b0;
    ram_din  = '0;
    if (w_ldrGnt) begin
      ram_addr = ldr_addr;
      ram_we   = ldr_we;
      ram_din  = ldr_wdata;
    end else if (w_cpuGnt) begin
      ram_addr = cpu_addr;
      ram_we   = w_cpuWrite;
      ram_din  = cpu_wdata;
    end
  end

  // Starvation counter and next owner of the RAM.
  always_comb begin
    w_nextStarve = '0;
    w_nextState  = IDLE;
    if (ldr_req && !w_ldrGnt) begin
      w_nextStarve = (r_starveCnt == STARVE_MAX) ? r_starveCnt : r_starveCnt + 1'b1;
    end
    if (w_ldrGnt) begin
      w_nextState = ldr_lock ? LOCK : LDR;
    end else if (w_cpuGnt) begin
      w_nextState = CPU;
    end else if ((r_state == LOCK) && ldr_lock) begin
      w_nextState = LOCK;
    end
  end

  // State, counter and address-hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_starveCnt <= '0;
      r_lastAddr  <= '0;
    end else begin
      r_state     <= w_nextState;
      r_starveCnt <= w_nextStarve;
      r_lastAddr  <= ram_addr;
    end
  end

  // Remember which requester issued a read so its data can be returned next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpuRd <= 1'b0;
      r_ldrRd <= 1'b0;
    end else begin
      r_cpuRd <= w_cpuGnt && w_cpuRead;
      r_ldrRd <= w_ldrGnt && !ldr_we;
    end
  end

  // Keep the last CPU read value so cpu_rdata is stable while others own the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpuRdata <= '0;
    end else if ((r_state == CPU) && r_cpuRd) begin
      r_cpuRdata <= ram_dout;
    end
  end

  // Requester-facing outputs; a reset discards any read still in flight.
  always_comb begin
    ldr_gnt   = w_ldrGnt;
    cpu_stall = w_cpuReq && !w_cpuGnt;
    ldr_rdata = ram_dout;
    ldr_valid = r_ldrRd && !reset;
    cpu_rdata = ((r_state == CPU) && r_cpuRd) ? ram_dout : r_cpuRdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives the arbiter against a behavioural synchronous RAM and
// checks grants, stalls, RAM drive and returned read data with a scoreboard.
module tb_mem_arbiter;

  localparam int AW     = 9;
  localparam int DW     = 16;
  localparam int STARVE = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    cpu_cmd;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          ldr_req;
  logic          ldr_we;
  logic          ldr_lock;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_gnt;
  logic [DW-1:0] ldr_rdata;
  logic          ldr_valid;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem    [0:511];
  logic [DW-1:0] shadow [0:511];
  logic [DW-1:0] expCpuQ [$];
  logic [DW-1:0] expLdrQ [$];
  logic [DW-1:0] lastCpuRdata = '0;
  int            compared     = 0;
  int            mismatched   = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_cmd   (cpu_cmd),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .ldr_req   (ldr_req),
    .ldr_we    (ldr_we),
    .ldr_lock  (ldr_lock),
    .ldr_addr  (ldr_addr),
    .ldr_wdata (ldr_wdata),
    .ldr_gnt   (ldr_gnt),
    .ldr_rdata (ldr_rdata),
    .ldr_valid (ldr_valid),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered read data.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] cmd, input logic [AW-1:0] cAddr, input logic [DW-1:0] cData,
                               input logic lReq, input logic lWe, input logic lLock,
                               input logic [AW-1:0] lAddr, input logic [DW-1:0] lData);
    cpu_cmd   = cmd;
    cpu_addr  = cAddr;
    cpu_wdata = cData;
    ldr_req   = lReq;
    ldr_we    = lWe;
    ldr_lock  = lLock;
    ldr_addr  = lAddr;
    ldr_wdata = lData;
  endtask

  task automatic applyIdle();
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // One clock cycle: check returns from the previous cycle, this cycle's
  // grant/stall/RAM drive, update the shadow memory and scoreboard, then advance.
  task automatic runCycle(input logic expLdrGnt, input logic expStall, input string tag);
    logic          cpuGnt;
    logic [DW-1:0] e;
    #3;
    if (reset) begin
      checkOutput({tag, "_validInReset"}, ldr_valid, 1'b0);
      expCpuQ.delete();
      expLdrQ.delete();
      lastCpuRdata = '0;
    end else begin
      if (expCpuQ.size() > 0) begin
        e = expCpuQ.pop_front();
        checkOutput({tag, "_cpuRdata"}, cpu_rdata, e);
        lastCpuRdata = e;
      end else begin
        checkOutput({tag, "_cpuRdataHold"}, cpu_rdata, lastCpuRdata);
      end
      checkOutput({tag, "_ldrValid"}, ldr_valid, expLdrQ.size() != 0);
      if (expLdrQ.size() > 0) begin
        e = expLdrQ.pop_front();
        checkOutput({tag, "_ldrRdata"}, ldr_rdata, e);
      end
    end
    checkOutput({tag, "_ldrGnt"}, ldr_gnt, expLdrGnt);
    checkOutput({tag, "_cpuStall"}, cpu_stall, expStall);
    cpuGnt = ((cpu_cmd == 2'b01) || (cpu_cmd == 2'b10)) && !expStall && !reset;
    if (expLdrGnt) begin
      checkOutput({tag, "_ramAddrL"}, ram_addr, ldr_addr);
      checkOutput({tag, "_ramWeL"}, ram_we, ldr_we);
      if (ldr_we) begin
        checkOutput({tag, "_ramDinL"}, ram_din, ldr_wdata);
        shadow[ldr_addr] = ldr_wdata;
      end else begin
        expLdrQ.push_back(shadow[ldr_addr]);
      end
    end else if (cpuGnt) begin
      checkOutput({tag, "_ramAddrC"}, ram_addr, cpu_addr);
      checkOutput({tag, "_ramWeC"}, ram_we, cpu_cmd == 2'b10);
      if (cpu_cmd == 2'b10) begin
        checkOutput({tag, "_ramDinC"}, ram_din, cpu_wdata);
        shadow[cpu_addr] = cpu_wdata;
      end else begin
        expCpuQ.push_back(shadow[cpu_addr]);
      end
    end else begin
      checkOutput({tag, "_ramWeIdle"}, ram_we, 1'b0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) shadow[i] = '0;
    reset = 1'b1;
    applyIdle();
    runCycle(1'b0, 1'b0, "rst0");
    runCycle(1'b0, 1'b0, "rst1");
    reset = 1'b0;

    // Reset values with no request present.
    #2;
    checkOutput("rstRamAddr", ram_addr, '0);
    runCycle(1'b0, 1'b0, "postRst");

    // Seed RAM[5] through the loader, then reset again before the CPU test.
    applyStimulus(2'b00, '0, '0, 1'b1, 1'b1, 1'b0, 9'h005, 16'hBEEF);
    runCycle(1'b1, 1'b0, "seed");
    reset = 1'b1;
    applyIdle();
    runCycle(1'b0, 1'b0, "rst2");
    reset = 1'b0;

    // CPU read of 0x005 with no loader.
    applyStimulus(2'b01, 9'h005, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    runCycle(1'b0, 1'b0, "cpuRd");
    applyIdle();
    runCycle(1'b0, 1'b0, "cpuRdRet");
    runCycle(1'b0, 1'b0, "cpuRdHold");

    // Loader write then read with the CPU idle.
    applyStimulus(2'b00, '0, '0, 1'b1, 1'b1, 1'b0, 9'h010, 16'h1234);
    runCycle(1'b1, 1'b0, "ldrWr");
    applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, 1'b0, 9'h010, '0);
    runCycle(1'b1, 1'b0, "ldrRd");
    applyIdle();
    runCycle(1'b0, 1'b0, "ldrRdRet");

    // Continuous CPU reads against a persistent loader read request.
    for (int c = 0; c < 10; c++) begin
      applyStimulus(2'b01, (c % 2 == 0) ? 9'h005 : 9'h010, '0, 1'b1, 1'b0, 1'b0, 9'h010, '0);
      runCycle((c == 4) || (c == 9), (c == 4) || (c == 9), $sformatf("starve%0d", c));
    end
    applyIdle();
    runCycle(1'b0, 1'b0, "starveDrain");

    // Locked download of 8 words while the CPU keeps asking for reads.
    for (int c = 0; c < 8; c++) begin
      applyStimulus((c == 0) ? 2'b00 : 2'b01, 9'h003, '0, 1'b1, 1'b1, 1'b1,
                    AW'(c), 16'hA000 + DW'(c));
      runCycle(1'b1, c != 0, $sformatf("lock%0d", c));
    end
    applyStimulus(2'b01, 9'h003, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    runCycle(1'b0, 1'b1, "lockDrop");
    runCycle(1'b0, 1'b0, "lockResume");
    applyIdle();
    runCycle(1'b0, 1'b0, "lockRet");

    // Same-cycle CPU write and loader read of the same address.
    applyStimulus(2'b10, 9'h020, 16'h00AA, 1'b1, 1'b0, 1'b0, 9'h020, '0);
    runCycle(1'b0, 1'b0, "collide");
    applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, 1'b0, 9'h020, '0);
    runCycle(1'b1, 1'b0, "collideLdr");
    applyIdle();
    runCycle(1'b0, 1'b0, "collideRet");

    // Reset in the cycle after a loader read grant.
    applyStimulus(2'b01, 9'h005, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    runCycle(1'b0, 1'b0, "midCpu");
    applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, 1'b1, 9'h010, '0);
    runCycle(1'b1, 1'b0, "midLdr");
    reset = 1'b1;
    applyIdle();
    runCycle(1'b0, 1'b0, "midRst");
    reset = 1'b0;
    #2;
    checkOutput("midRamAddr", ram_addr, '0);
    runCycle(1'b0, 1'b0, "midAfter");
    applyStimulus(2'b01, 9'h020, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    runCycle(1'b0, 1'b0, "midCpuAgain");
    applyIdle();
    runCycle(1'b0, 1'b0, "midCpuRet");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single-port 512x16 instruction/data RAM between the CPU memory port (`mem_cmd`/`mem_addr`/`write_data`) and a secondary requester: the program loader, or a debug or DMA port. CPU requests win by default. The loader is guaranteed service after a bounded wait, and it can lock the RAM for back-to-back program download while the CPU is held in stall. The block sits between `cpu` and the RAM and routes synchronous-read data back to whichever requester owned the previous cycle.

## Interface
- `AW`, 9: RAM address width.
- `DW`, 16: RAM data width.
- `STARVE`, 4: maximum consecutive cycles a pending loader request may lose to the CPU.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `cpu_cmd` in 2: 00 none, 01 read, 10 write, 11 treated as none.
- `cpu_addr` in AW: CPU address.
- `cpu_wdata` in DW: CPU write data.
- `cpu_rdata` out DW: read data returned to the CPU.
- `cpu_stall` out 1: CPU access this cycle was not performed.
- `ldr_req` in 1: loader request, held until granted.
- `ldr_we` in 1: loader write (1) or read (0).
- `ldr_lock` in 1: with `ldr_req`, keep ownership after grant.
- `ldr_addr` in AW: loader address.
- `ldr_wdata` in DW: loader write data.
- `ldr_gnt` out 1: loader access performed this cycle.
- `ldr_rdata` out DW: loader read data.
- `ldr_valid` out 1: `ldr_rdata` valid this cycle.
- `ram_addr` out AW: RAM address.
- `ram_we` out 1: RAM write enable.
- `ram_din` out DW: RAM write data.
- `ram_dout` in DW: RAM read data, registered, valid one cycle after the address.

## Operation
- FSM states: IDLE, CPU, LDR, LOCK. The state records the owner of the RAM in the cycle just completed.
- Grant decision (combinational, every cycle):
  - In LOCK, the loader is granted whenever `ldr_req` is high.
  - Otherwise, the loader is granted if `ldr_req` is high and either `cpu_cmd` is none/11 or `starve_cnt == STARVE`.
  - Otherwise, the CPU is granted if `cpu_cmd` is 01 or 10.
- RAM drive:
  - On a loader grant: `ram_addr = ldr_addr`, `ram_we = ldr_we`, `ram_din = ldr_wdata`.
  - On a CPU grant: `ram_addr = cpu_addr`, `ram_we = (cpu_cmd == 10)`, `ram_din = cpu_wdata`.
  - With no grant: `ram_we = 0` and `ram_addr` holds its last value.
- `cpu_stall` = (`cpu_cmd` is 01 or 10) and not CPU-granted.
- `starve_cnt` (width clog2(STARVE+1)):
  - increments when `ldr_req` is high and the loader is not granted, saturating at STARVE;
  - clears on a loader grant or when `ldr_req` is low.
- Next state:
  - loader grant with `ldr_lock` high: LOCK;
  - loader grant with `ldr_lock` low: LDR;
  - CPU grant: CPU;
  - no grant: IDLE.
  - LOCK with `ldr_lock` low returns through LDR on a grant, or IDLE without one.
- Read return:
  - In state CPU after a read, `cpu_rdata = ram_dout`. In every other state, `cpu_rdata` holds the last CPU read value from an internal register, which captures `ram_dout` in state CPU.
  - `ldr_valid = 1` exactly in the cycle after a loader read grant; `ldr_rdata = ram_dout`.
- Simultaneous CPU and loader requests in the same cycle with `starve_cnt < STARVE`: the CPU wins and `starve_cnt` increments.
- Reset mid-transfer: the pending read return is discarded and `ldr_valid` is not asserted afterwards. A locked loader must re-request.

## Timing
- Reset values:
  - state IDLE, `starve_cnt` 0, internal CPU read register 0;
  - hence `cpu_rdata` 0, `ldr_valid` 0, `ram_we` 0, `ram_addr` 0 in the first cycle after reset, when no request is present.
- Grant and stall are same-cycle combinational; no added latency on the write path.
- Read latency: 1 cycle for both requesters, matching the CPU IF1→IF2 sequence.
- Worst-case loader wait with continuous CPU traffic: STARVE+1 cycles from `ldr_req` rise to `ldr_gnt`.
- In LOCK, the CPU stalls on every request until the cycle after `ldr_lock` falls with no `ldr_req`.

## Test plan
- Reset, then CPU read at 0x005 with RAM[5]=0xBEEF and no loader → `cpu_stall` 0; `cpu_rdata` = 0xBEEF one cycle later.
- Idle CPU, loader write 0x1234 to 0x010, then loader read of 0x010 → `ldr_gnt` 1 same cycle; `ldr_valid` 1 with `ldr_rdata` 0x1234 one cycle after the read grant; `cpu_rdata` unchanged.
- CPU reading every cycle with `ldr_req` high from cycle 0, STARVE=4 → `ldr_gnt` first in cycle 4, CPU stalled exactly that cycle, `starve_cnt` back to 0.
- `ldr_lock` high, 8 consecutive loader writes to 0x000-0x007 while CPU requests reads → 8 grants back-to-back, `cpu_stall` 1 throughout; the CPU resumes the cycle after the lock drops.
- Same-cycle CPU write 0x00AA to 0x020 and loader read of 0x020 with `starve_cnt` 0 → CPU wins; in the next cycle the loader read returns 0x00AA.
- `reset` asserted in the cycle after a loader read grant → `ldr_valid` stays 0, state IDLE, `cpu_rdata` 0.
